// File: rtl/debug_cmd_sysclk_queue.sv
// debug_cmd_sysclk_queue
// Moves virtual-JTAG update strobes into the system clock domain, queues each
// captured {instruction, shift-register} command in a small FWFT queue and
// emits a one-cycle action / no-action pulse per instruction code on pop.
module debug_cmd_sysclk_queue #(
  parameter int DATA_W      = 38,
  parameter int IR_W        = 2,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int ACT_BIT     = 34
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [IR_W-1:0]           ir_in,
  input  logic [DATA_W-1:0]         sr,
  input  logic                      vs_uir,
  input  logic                      vs_udr,
  output logic                      cmd_valid,
  input  logic                      cmd_ready,
  output logic [IR_W-1:0]           cmd_ir,
  output logic [DATA_W-1:0]         cmd_data,
  output logic [(1<<IR_W)-1:0]      take_action,
  output logic [(1<<IR_W)-1:0]      take_no_action,
  output logic [$clog2(DEPTH):0]    fill,
  output logic                      overflow,
  input  logic                      clr_overflow
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FILL_W = $clog2(DEPTH) + 1;
  localparam int NCODE  = 1 << IR_W;
  localparam int ENT_W  = IR_W + DATA_W;

  logic [SYNC_STAGES-1:0] r_uir_sync;
  logic [SYNC_STAGES-1:0] r_udr_sync;
  logic [SYNC_STAGES-1:0] r_prime;
  logic                   r_uir_dly;
  logic                   r_udr_dly;
  logic                   r_uir_arm;
  logic                   r_udr_arm;
  logic [IR_W-1:0]        r_ir_latched;
  logic [ENT_W-1:0]       r_mem [DEPTH];
  logic [PTR_W-1:0]       r_wptr;
  logic [PTR_W-1:0]       r_rptr;
  logic [FILL_W-1:0]      r_fill;
  logic                   r_valid;
  logic                   r_overflow;
  logic [NCODE-1:0]       r_take_act;
  logic [NCODE-1:0]       r_take_noact;

  logic                   w_uir_lvl;
  logic                   w_udr_lvl;
  logic                   w_primed;
  logic                   w_uir_rise;
  logic                   w_udr_rise;
  logic                   w_full;
  logic                   w_pop;
  logic                   w_wr;
  logic                   w_drop;
  logic [FILL_W-1:0]      w_fill_nxt;
  logic [ENT_W-1:0]       w_head;
  logic [NCODE-1:0]       w_onehot;

  // The prime chain marks when the synchronisers hold real samples rather than
  // reset values, so a strobe held high through reset never arms.
  assign w_uir_lvl  = r_uir_sync[SYNC_STAGES-1];
  assign w_udr_lvl  = r_udr_sync[SYNC_STAGES-1];
  assign w_primed   = r_prime[SYNC_STAGES-1];
  assign w_uir_rise = w_uir_lvl & ~r_uir_dly & r_uir_arm;
  assign w_udr_rise = w_udr_lvl & ~r_udr_dly & r_udr_arm;

  assign w_full   = (r_fill == FILL_W'(DEPTH));
  assign w_pop    = r_valid & cmd_ready;
  assign w_wr     = w_udr_rise & (~w_full | w_pop);
  assign w_drop   = w_udr_rise & w_full & ~w_pop;
  assign w_head   = r_mem[r_rptr];
  assign w_onehot = NCODE'(1) << cmd_ir;

  assign cmd_valid      = r_valid;
  assign cmd_ir         = w_head[ENT_W-1:DATA_W];
  assign cmd_data       = w_head[DATA_W-1:0];
  assign take_action    = r_take_act;
  assign take_no_action = r_take_noact;
  assign fill           = r_fill;
  assign overflow       = r_overflow;

  // Strobe synchronisers, edge-detect delay flops and arm flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_uir_sync <= {SYNC_STAGES{1'b0}};
      r_udr_sync <= {SYNC_STAGES{1'b0}};
      r_prime    <= {SYNC_STAGES{1'b0}};
      r_uir_dly  <= 1'b0;
      r_udr_dly  <= 1'b0;
      r_uir_arm  <= 1'b0;
      r_udr_arm  <= 1'b0;
    end else begin
      r_uir_sync <= {r_uir_sync[SYNC_STAGES-2:0], vs_uir};
      r_udr_sync <= {r_udr_sync[SYNC_STAGES-2:0], vs_udr};
      r_prime    <= {r_prime[SYNC_STAGES-2:0], 1'b1};
      r_uir_dly  <= w_uir_lvl;
      r_udr_dly  <= w_udr_lvl;
      r_uir_arm  <= r_uir_arm | (w_primed & ~w_uir_lvl);
      r_udr_arm  <= r_udr_arm | (w_primed & ~w_udr_lvl);
    end
  end

  // Instruction capture on update-IR; a same-cycle push still sees the old value.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ir_latched <= {IR_W{1'b0}};
    end else if (w_uir_rise) begin
      r_ir_latched <= ir_in;
    end else begin
      r_ir_latched <= r_ir_latched;
    end
  end

  // Next occupancy from the accepted push and pop of this cycle.
  always_comb begin
    w_fill_nxt = r_fill;
    if (w_wr && !w_pop) begin
      w_fill_nxt = r_fill + FILL_W'(1);
    end else if (!w_wr && w_pop) begin
      w_fill_nxt = r_fill - FILL_W'(1);
    end else begin
      w_fill_nxt = r_fill;
    end
  end

  // Queue storage; contents are don't-care while empty so no reset is needed.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wptr] <= {r_ir_latched, sr};
    end
  end

  // Pointers, occupancy and head-valid flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= {PTR_W{1'b0}};
      r_rptr  <= {PTR_W{1'b0}};
      r_fill  <= {FILL_W{1'b0}};
      r_valid <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      r_fill  <= w_fill_nxt;
      r_valid <= (w_fill_nxt != FILL_W'(0));
    end
  end

  // Sticky overflow; a new drop in the same cycle beats the clear request.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (clr_overflow) begin
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= r_overflow;
    end
  end

  // One-cycle per-code pulse following each pop, split by the action bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_take_act   <= {NCODE{1'b0}};
      r_take_noact <= {NCODE{1'b0}};
    end else if (w_pop) begin
      if (cmd_data[ACT_BIT]) begin
        r_take_act   <= w_onehot;
        r_take_noact <= {NCODE{1'b0}};
      end else begin
        r_take_act   <= {NCODE{1'b0}};
        r_take_noact <= w_onehot;
      end
    end else begin
      r_take_act   <= {NCODE{1'b0}};
      r_take_noact <= {NCODE{1'b0}};
    end
  end

endmodule

// File: tb/tb_debug_cmd_sysclk_queue.sv
// Directed bench for debug_cmd_sysclk_queue with default parameters.
module tb_debug_cmd_sysclk_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  ir_in = 2'd0;
  logic [37:0] sr = 38'd0;
  logic        vs_uir = 1'b0;
  logic        vs_udr = 1'b0;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic [1:0]  cmd_ir;
  logic [37:0] cmd_data;
  logic [3:0]  take_action;
  logic [3:0]  take_no_action;
  logic [2:0]  fill;
  logic        overflow;
  logic        clr_overflow = 1'b0;

  int checks = 0;
  int failures = 0;

  debug_cmd_sysclk_queue dut (
    .clk(clk), .reset(reset), .ir_in(ir_in), .sr(sr),
    .vs_uir(vs_uir), .vs_udr(vs_udr),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ir(cmd_ir), .cmd_data(cmd_data),
    .take_action(take_action), .take_no_action(take_no_action),
    .fill(fill), .overflow(overflow), .clr_overflow(clr_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  ir;
    logic [37:0] data;
    logic [3:0]  exp_ta;
    logic [3:0]  exp_tna;
  } vec_t;

  vec_t vecs [4];
  logic [37:0] dq [5];

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(4);
  endtask

  task automatic pulse_uir(input logic [1:0] code);
    ir_in  = code;
    vs_uir = 1'b1;
    tick(4);
    vs_uir = 1'b0;
    tick(4);
  endtask

  task automatic pulse_udr(input logic [37:0] data);
    sr     = data;
    vs_udr = 1'b1;
    tick(4);
    vs_udr = 1'b0;
    tick(4);
  endtask

  initial begin
    vecs[0] = '{ir: 2'd0, data: 38'h04_1234_5678, exp_ta: 4'b0001, exp_tna: 4'b0000};
    vecs[1] = '{ir: 2'd1, data: 38'h03_ABCD_0001, exp_ta: 4'b0000, exp_tna: 4'b0010};
    vecs[2] = '{ir: 2'd3, data: 38'h3F_FFFF_FFFF, exp_ta: 4'b1000, exp_tna: 4'b0000};
    vecs[3] = '{ir: 2'd2, data: 38'h2A_5555_AAAA, exp_ta: 4'b0000, exp_tna: 4'b0100};
    dq[0] = 38'h04_0000_0011;
    dq[1] = 38'h00_0000_0022;
    dq[2] = 38'h05_0000_0033;
    dq[3] = 38'h01_0000_0044;
    dq[4] = 38'h07_0000_0055;

    // Reset state
    tick(1);
    do_reset();
    check("rst_valid", cmd_valid, 1'b0);
    check("rst_fill", fill, 3'd0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_ta", take_action, 4'b0000);
    check("rst_tna", take_no_action, 4'b0000);

    // Latency and first pop with default parameters
    pulse_uir(2'd2);
    sr        = 38'h04_0000_00AA;
    vs_udr    = 1'b1;
    cmd_ready = 1'b1;
    tick(2);
    check("lat_edge2_valid", cmd_valid, 1'b0);
    tick(1);
    check("lat_edge3_valid", cmd_valid, 1'b1);
    check("lat_ir", cmd_ir, 2'd2);
    tick(1);
    check("lat_ta", take_action, 4'b0100);
    check("lat_tna", take_no_action, 4'b0000);
    tick(1);
    check("lat_ta_gone", take_action, 4'b0000);
    vs_udr    = 1'b0;
    cmd_ready = 1'b0;
    tick(4);

    // Table-driven per-code action/no-action pulses
    for (int i = 0; i < 4; i++) begin
      pulse_uir(vecs[i].ir);
      pulse_udr(vecs[i].data);
      check("tbl_valid", cmd_valid, 1'b1);
      check("tbl_ir", cmd_ir, vecs[i].ir);
      check("tbl_data", cmd_data, vecs[i].data);
      cmd_ready = 1'b1;
      tick(1);
      cmd_ready = 1'b0;
      check("tbl_ta", take_action, vecs[i].exp_ta);
      check("tbl_tna", take_no_action, vecs[i].exp_tna);
      tick(1);
      check("tbl_ta_1cyc", take_action, 4'b0000);
      check("tbl_tna_1cyc", take_no_action, 4'b0000);
      check("tbl_empty", cmd_valid, 1'b0);
    end

    // Overflow: five pushes into a four-deep queue
    do_reset();
    for (int i = 0; i < 5; i++) pulse_udr(dq[i]);
    check("ovf_fill", fill, 3'd4);
    check("ovf_flag", overflow, 1'b1);
    // New overflow coincident with clear: overflow remains set
    sr     = 38'h00_0000_0066;
    vs_udr = 1'b1;
    tick(2);
    clr_overflow = 1'b1;
    tick(1);
    clr_overflow = 1'b0;
    check("ovf_clr_race", overflow, 1'b1);
    check("ovf_fill_race", fill, 3'd4);
    vs_udr = 1'b0;
    tick(4);
    for (int i = 0; i < 4; i++) begin
      check("drain_valid", cmd_valid, 1'b1);
      check("drain_data", cmd_data, dq[i]);
      cmd_ready = 1'b1;
      tick(1);
      cmd_ready = 1'b0;
    end
    check("drain_fill", fill, 3'd0);
    check("drain_valid_lo", cmd_valid, 1'b0);
    check("ovf_sticky", overflow, 1'b1);
    cmd_ready = 1'b1;
    tick(2);
    cmd_ready = 1'b0;
    check("ready_no_valid_fill", fill, 3'd0);
    clr_overflow = 1'b1;
    tick(1);
    clr_overflow = 1'b0;
    check("ovf_cleared", overflow, 1'b0);

    // Full queue, push coincident with pop
    do_reset();
    for (int i = 0; i < 4; i++) pulse_udr(dq[i]);
    check("full_fill", fill, 3'd4);
    sr     = dq[4];
    vs_udr = 1'b1;
    tick(2);
    cmd_ready = 1'b1;
    tick(1);
    cmd_ready = 1'b0;
    check("pushpop_fill", fill, 3'd4);
    check("pushpop_ovf", overflow, 1'b0);
    vs_udr = 1'b0;
    tick(4);
    for (int i = 1; i < 5; i++) begin
      check("pushpop_order", cmd_data, dq[i]);
      cmd_ready = 1'b1;
      tick(1);
      cmd_ready = 1'b0;
    end
    check("pushpop_empty", cmd_valid, 1'b0);

    // vs_udr held high across reset release
    vs_udr = 1'b1;
    reset  = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(8);
    check("held_no_push_fill", fill, 3'd0);
    check("held_no_push_valid", cmd_valid, 1'b0);
    vs_udr = 1'b0;
    tick(4);
    check("held_low_fill", fill, 3'd0);
    pulse_udr(38'h00_0000_0077);
    check("held_rearm_fill", fill, 3'd1);

    // Same-cycle uir and udr rises
    do_reset();
    pulse_uir(2'd1);
    ir_in  = 2'd3;
    sr     = 38'h00_0000_0088;
    vs_uir = 1'b1;
    vs_udr = 1'b1;
    tick(4);
    vs_uir = 1'b0;
    vs_udr = 1'b0;
    tick(4);
    check("same_cyc_ir_old", cmd_ir, 2'd1);
    pulse_udr(38'h00_0000_0099);
    check("same_cyc_fill", fill, 3'd2);
    cmd_ready = 1'b1;
    tick(1);
    cmd_ready = 1'b0;
    check("same_cyc_ir_new", cmd_ir, 2'd3);
    check("same_cyc_data_new", cmd_data, 38'h00_0000_0099);

    // Reset with entries queued
    do_reset();
    for (int i = 0; i < 3; i++) pulse_udr(dq[i]);
    check("mid_fill3", fill, 3'd3);
    reset     = 1'b1;
    cmd_ready = 1'b1;
    tick(2);
    reset = 1'b0;
    check("mid_rst_fill", fill, 3'd0);
    check("mid_rst_valid", cmd_valid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check("mid_rst_ta", take_action, 4'b0000);
      check("mid_rst_tna", take_no_action, 4'b0000);
    end
    check("mid_rst_fill_after", fill, 3'd0);
    cmd_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
